// File: rtl/ram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the single-ported RAM slave; grant held for the whole cyc.
// Define RAM_WB_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: fixed priority, m0 first).
module ram_wb_arbiter #(
    parameter int ADR_WIDTH    = 16,
    parameter int STARVE_LIMIT = 256,
    parameter int WAIT_WIDTH   = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic [31:0]          m0_dat_i,
    output logic [31:0]          m0_dat_o,
    input  logic [ADR_WIDTH-3:0] m0_adr_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic [3:0]           m0_sel_i,
    input  logic [2:0]           m0_cti_i,
    output logic                 m0_ack_o,

    input  logic [31:0]          m1_dat_i,
    output logic [31:0]          m1_dat_o,
    input  logic [ADR_WIDTH-3:0] m1_adr_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic [3:0]           m1_sel_i,
    input  logic [2:0]           m1_cti_i,
    output logic                 m1_ack_o,

    output logic [31:0]          s_dat_o,
    input  logic [31:0]          s_dat_i,
    output logic [ADR_WIDTH-3:0] s_adr_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic [3:0]           s_sel_o,
    output logic [2:0]           s_cti_o,
    input  logic                 s_ack_i,

    input  logic                 starve_clr_i,
    output logic                 starve_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(STARVE_LIMIT - 1);

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                  starve_q, starve_d;

    // Per-master views indexed by master number so routing is a single mux.
    logic [31:0]          m_dat [2];
    logic [ADR_WIDTH-3:0] m_adr [2];
    logic                 m_we  [2];
    logic                 m_cyc [2];
    logic                 m_stb [2];
    logic [3:0]           m_sel [2];
    logic [2:0]           m_cti [2];
    logic                 m_ack [2];

    assign m_dat[0] = m0_dat_i;
    assign m_adr[0] = m0_adr_i;
    assign m_we[0]  = m0_we_i;
    assign m_cyc[0] = m0_cyc_i;
    assign m_stb[0] = m0_stb_i;
    assign m_sel[0] = m0_sel_i;
    assign m_cti[0] = m0_cti_i;

    assign m_dat[1] = m1_dat_i;
    assign m_adr[1] = m1_adr_i;
    assign m_we[1]  = m1_we_i;
    assign m_cyc[1] = m1_cyc_i;
    assign m_stb[1] = m1_stb_i;
    assign m_sel[1] = m1_sel_i;
    assign m_cti[1] = m1_cti_i;

    logic own_valid;
    logic own_idx;
    logic other_waiting;
    logic tie_pick_m1;
    logic starve_set;

    assign own_valid     = (state_q == OWN0) || (state_q == OWN1);
    assign own_idx       = (state_q == OWN1);
    assign other_waiting = own_valid && m_cyc[~own_idx];

`ifdef RAM_WB_ARB_ROUND_ROBIN_EN
    assign tie_pick_m1 = ~last_q;
`else
    assign tie_pick_m1 = 1'b0;
`endif

    // Slave side: owner's signals pass straight through, all zeros while idle.
    always_comb begin
        s_dat_o = '0;
        s_adr_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_sel_o = '0;
        s_cti_o = '0;
        if (own_valid) begin
            s_dat_o = m_dat[own_idx];
            s_adr_o = m_adr[own_idx];
            s_we_o  = m_we[own_idx];
            s_cyc_o = m_cyc[own_idx];
            s_stb_o = m_stb[own_idx];
            s_sel_o = m_sel[own_idx];
            s_cti_o = m_cti[own_idx];
        end
    end

    // Acks are gated by state so an asynchronous reset drops them immediately.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign m_ack[gi] = own_valid && (own_idx == 1'(gi)) && s_ack_i;
        end
    endgenerate

    assign m0_ack_o = m_ack[0];
    assign m1_ack_o = m_ack[1];
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign starve_o = starve_q;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m_cyc[0] && m_cyc[1]) begin
                    state_d = tie_pick_m1 ? OWN1 : OWN0;
                end else if (m_cyc[0]) begin
                    state_d = OWN0;
                end else if (m_cyc[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!m_cyc[0]) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!m_cyc[1]) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign starve_set = other_waiting && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d == IDLE) begin
            wait_cnt_d = '0;
        end else if (other_waiting && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    assign starve_d = starve_set || (starve_q && !starve_clr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            wait_cnt_q <= '0;
            starve_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
            starve_q   <= starve_d;
        end
    end

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Randomized and directed bench for ram_wb_arbiter against an owner/wait-count reference model.
module tb_ram_wb_arbiter;
    localparam int AW  = 16;
    localparam int AWW = AW - 2;
    localparam int LIM = 8;
    localparam int WW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]    m_dat_w [2];
    logic [AWW-1:0] m_adr   [2];
    logic           m_we    [2];
    logic           m_cyc   [2];
    logic           m_stb   [2];
    logic [3:0]     m_sel   [2];
    logic [2:0]     m_cti   [2];
    logic [31:0]    m0_dat_r, m1_dat_r;
    logic           m0_ack, m1_ack;
    logic [31:0]    s_dat_w, s_dat_r;
    logic [AWW-1:0] s_adr;
    logic           s_we, s_cyc, s_stb, s_ack;
    logic [3:0]     s_sel;
    logic [2:0]     s_cti;
    logic           starve_clr, starve;

    ram_wb_arbiter #(.ADR_WIDTH(AW), .STARVE_LIMIT(LIM), .WAIT_WIDTH(WW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_dat_i(m_dat_w[0]), .m0_dat_o(m0_dat_r), .m0_adr_i(m_adr[0]), .m0_we_i(m_we[0]),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_sel_i(m_sel[0]), .m0_cti_i(m_cti[0]),
        .m0_ack_o(m0_ack),
        .m1_dat_i(m_dat_w[1]), .m1_dat_o(m1_dat_r), .m1_adr_i(m_adr[1]), .m1_we_i(m_we[1]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_sel_i(m_sel[1]), .m1_cti_i(m_cti[1]),
        .m1_ack_o(m1_ack),
        .s_dat_o(s_dat_w), .s_dat_i(s_dat_r), .s_adr_o(s_adr), .s_we_o(s_we), .s_cyc_o(s_cyc),
        .s_stb_o(s_stb), .s_sel_o(s_sel), .s_cti_o(s_cti), .s_ack_i(s_ack),
        .starve_clr_i(starve_clr), .starve_o(starve)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: current owner (-1 none), last served master, cycles the other master has waited.
    int own_m   = -1;
    int last_m  = 1;
    int waited  = 0;
    bit starve_m = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit v;
        int o;
        v = (own_m >= 0);
        o = v ? own_m : 0;
        check_value("s_cyc",  32'(s_cyc),   v ? 32'(m_cyc[o]) : 32'd0);
        check_value("s_stb",  32'(s_stb),   v ? 32'(m_stb[o]) : 32'd0);
        check_value("s_we",   32'(s_we),    v ? 32'(m_we[o])  : 32'd0);
        check_value("s_adr",  32'(s_adr),   v ? 32'(m_adr[o]) : 32'd0);
        check_value("s_dat",  s_dat_w,      v ? m_dat_w[o]    : 32'd0);
        check_value("s_sel",  32'(s_sel),   v ? 32'(m_sel[o]) : 32'd0);
        check_value("s_cti",  32'(s_cti),   v ? 32'(m_cti[o]) : 32'd0);
        check_value("m0_ack", 32'(m0_ack),  32'(own_m == 0 && s_ack));
        check_value("m1_ack", 32'(m1_ack),  32'(own_m == 1 && s_ack));
        check_value("m0_dat", m0_dat_r,     s_dat_r);
        check_value("m1_dat", m1_dat_r,     s_dat_r);
        check_value("starve", 32'(starve),  32'(starve_m));
    endtask

    task automatic model_step();
        bit waiting;
        bit set;
        int nxt;
        waiting = (own_m >= 0) && m_cyc[1 - own_m];
        nxt = own_m;
        if (own_m < 0) begin
            if (m_cyc[0] && m_cyc[1]) begin
`ifdef RAM_WB_ARB_ROUND_ROBIN_EN
                nxt = (last_m == 0) ? 1 : 0;
`else
                nxt = 0;
`endif
            end else if (m_cyc[0]) nxt = 0;
            else if (m_cyc[1]) nxt = 1;
        end else if (!m_cyc[own_m]) begin
            last_m = own_m;
            nxt = -1;
        end
        if (waiting) waited++;
        set = waiting && (waited == LIM);
        starve_m = set ? 1'b1 : (starve_clr ? 1'b0 : starve_m);
        if (nxt < 0) waited = 0;
        own_m = nxt;
    endtask

    task automatic half_cycle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            m_dat_w[i] = '0; m_adr[i] = '0; m_we[i] = 1'b0; m_cyc[i] = 1'b0;
            m_stb[i] = 1'b0; m_sel[i] = '0; m_cti[i] = '0;
        end
        s_dat_r = '0; s_ack = 1'b0; starve_clr = 1'b0;
    endtask

    // Asynchronous reset applied mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_value("rst_m0_ack", 32'(m0_ack), 32'd0);
        check_value("rst_m1_ack", 32'(m1_ack), 32'd0);
        check_value("rst_s_cyc",  32'(s_cyc),  32'd0);
        check_value("rst_starve", 32'(starve), 32'd0);
        own_m = -1; last_m = 1; waited = 0; starve_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] burst_adr;
    bit tie_exp [3];

    initial begin
        idle_inputs();
        #2;
        do_reset();

        // Solo m0 classic read
        m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = AWW'('h010); m_sel[0] = 4'hF;
        half_cycle(); check_value("t1_idle", 32'(s_cyc), 32'd0); clock_edge();
        s_ack = 1; s_dat_r = 32'h1234_5678;
        half_cycle();
        check_value("t1_scyc", 32'(s_cyc), 32'd1);
        check_value("t1_ack0", 32'(m0_ack), 32'd1);
        check_value("t1_ack1", 32'(m1_ack), 32'd0);
        clock_edge();
        s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0;
        half_cycle(); clock_edge();
        half_cycle(); check_value("t1_back_idle", 32'(s_cyc), 32'd0); clock_edge();

        // m1 incrementing burst with m0 arriving on beat 2
        m_cyc[1] = 1; m_stb[1] = 1; m_cti[1] = 3'b010; burst_adr = 32'h20;
        m_adr[1] = AWW'(burst_adr);
        half_cycle(); clock_edge();
        for (int b = 0; b < 4; b++) begin
            m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
            m_adr[1] = AWW'(burst_adr + 32'(b));
            s_ack = 1;
            if (b == 1) begin m_cyc[0] = 1; m_stb[0] = 1; end
            half_cycle();
            check_value("t2_ack1", 32'(m1_ack), 32'd1);
            check_value("t2_ack0", 32'(m0_ack), 32'd0);
            clock_edge();
        end
        m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
        half_cycle(); clock_edge();
        half_cycle(); check_value("t2_bubble", 32'(s_cyc), 32'd0); clock_edge();
        s_ack = 1;
        half_cycle(); check_value("t2_m0_grant", 32'(m0_ack), 32'd1); clock_edge();
        m_cyc[0] = 0; m_stb[0] = 0; s_ack = 0;
        half_cycle(); clock_edge();
        half_cycle(); clock_edge();

        // Three back-to-back ties
        do_reset();
`ifdef RAM_WB_ARB_ROUND_ROBIN_EN
        tie_exp[0] = 0; tie_exp[1] = 1; tie_exp[2] = 0;
`else
        tie_exp[0] = 0; tie_exp[1] = 0; tie_exp[2] = 0;
`endif
        for (int k = 0; k < 3; k++) begin
            m_cyc[0] = 1; m_stb[0] = 1; m_dat_w[0] = 32'hA000_0000 + 32'(k);
            m_cyc[1] = 1; m_stb[1] = 1; m_dat_w[1] = 32'hB000_0000 + 32'(k);
            half_cycle(); clock_edge();
            s_ack = 1;
            half_cycle();
            check_value("t3_grant_m1", 32'(m1_ack), 32'(tie_exp[k]));
            check_value("t3_grant_m0", 32'(m0_ack), 32'(!tie_exp[k]));
            clock_edge();
            m_cyc[0] = 0; m_stb[0] = 0; m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
            half_cycle(); clock_edge();
            half_cycle(); clock_edge();
        end

        // Starvation: m0 holds the bus for 20 cycles while m1 waits
        do_reset();
        m_cyc[0] = 1; m_stb[0] = 1;
        half_cycle(); clock_edge();
        m_cyc[1] = 1; m_stb[1] = 1;
        for (int i = 1; i <= 20; i++) begin
            half_cycle();
            if (i == LIM)     check_value("t4_not_yet", 32'(starve), 32'd0);
            if (i == LIM + 1) check_value("t4_set",     32'(starve), 32'd1);
            clock_edge();
        end
        m_cyc[0] = 0; m_stb[0] = 0;
        half_cycle(); clock_edge();
        half_cycle(); clock_edge();
        s_ack = 1;
        half_cycle(); check_value("t4_m1_served", 32'(m1_ack), 32'd1); clock_edge();
        m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
        half_cycle(); clock_edge();
        half_cycle(); check_value("t4_sticky", 32'(starve), 32'd1); clock_edge();
        starve_clr = 1;
        half_cycle(); clock_edge();
        starve_clr = 0;
        half_cycle(); check_value("t4_cleared", 32'(starve), 32'd0); clock_edge();

        // Reset in the middle of an m0 burst with m1 starving
        m_cyc[0] = 1; m_stb[0] = 1; m_cti[0] = 3'b010;
        half_cycle(); clock_edge();
        m_cyc[1] = 1; m_stb[1] = 1; s_ack = 1;
        for (int i = 0; i < 10; i++) begin
            half_cycle(); clock_edge();
        end
        half_cycle();
        check_value("t5_pre_starve", 32'(starve), 32'd1);
        check_value("t5_pre_ack",    32'(m0_ack), 32'd1);
        do_reset();
        idle_inputs();
        half_cycle(); clock_edge();

        // m1 byte write routing
        m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_sel[1] = 4'b0100;
        m_dat_w[1] = 32'hAABB_CCDD; m_adr[1] = AWW'('h3F);
        half_cycle(); clock_edge();
        half_cycle();
        check_value("t6_sel", 32'(s_sel), 32'h4);
        check_value("t6_dat", s_dat_w,    32'hAABB_CCDD);
        check_value("t6_adr", 32'(s_adr), 32'h3F);
        check_value("t6_we",  32'(s_we),  32'd1);
        clock_edge();
        idle_inputs();
        half_cycle(); clock_edge();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 9) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i]   = 1'($urandom);
                m_we[i]    = 1'($urandom);
                m_adr[i]   = AWW'($urandom);
                m_dat_w[i] = $urandom;
                m_sel[i]   = 4'($urandom);
                m_cti[i]   = 3'($urandom);
            end
            s_ack      = 1'($urandom);
            s_dat_r    = $urandom;
            starve_clr = ($urandom_range(0, 15) == 0);
            half_cycle();
            if ($urandom_range(0, 499) == 0) do_reset();
            else clock_edge();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
